// File: rtl/ceespu_fetch_buffer.sv
// Instruction-fetch front end: one imem read per cycle, PC-tagged response FIFO, valid/ready to decode.
// Optional macro CEESPU_FETCH_BYPASS_EN forwards a response straight to decode when the FIFO is empty.
module ceespu_fetch_buffer #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic              I_clk,
  input  logic              I_rst,
  input  logic [ADDR_W-1:0] I_PC,
  output logic              O_stall,
  input  logic              I_flush,
  output logic              O_imem_en,
  output logic [ADDR_W-1:0] O_imem_addr,
  input  logic [DATA_W-1:0] I_imem_data,
  output logic [DATA_W-1:0] O_instr,
  output logic [ADDR_W-1:0] O_instr_pc,
  output logic              O_valid,
  input  logic              I_ready
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(DEPTH);

  logic [CNT_W-1:0]  count;
  logic [PTR_W-1:0]  rd_ptr, wr_ptr;
  logic              inflight;
  logic [ADDR_W-1:0] pc_q;

  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [ADDR_W-1:0] pc_mem   [DEPTH];

  logic              fifo_empty;
  logic [CNT_W:0]    credit_used;
  logic              resp_ok;
  logic              bypass;
  logic              push;
  logic              pop;

  assign fifo_empty  = (count == '0);
  // Credit counts the outstanding request too, so an in-flight response always has a slot.
  assign credit_used = {1'b0, count} + (CNT_W + 1)'(inflight);
  assign O_stall     = I_rst | I_flush | (credit_used >= DEPTH_C);
  assign O_imem_en   = ~O_stall;
  assign O_imem_addr = I_PC;

  // A response arriving during a flush belongs to the abandoned path.
  assign resp_ok = inflight & ~I_flush;

`ifdef CEESPU_FETCH_BYPASS_EN
  assign bypass = resp_ok & fifo_empty;
`else
  assign bypass = 1'b0;
`endif

  // NOTE: every output of a combinational block gets a default first so no latch is inferred.
  always_comb begin
    O_valid    = 1'b0;
    O_instr    = '0;
    O_instr_pc = '0;
    if (!I_rst) begin
      if (!fifo_empty) begin
        O_valid    = 1'b1;
        O_instr    = data_mem[rd_ptr];
        O_instr_pc = pc_mem[rd_ptr];
      end else if (bypass) begin
        O_valid    = 1'b1;
        O_instr    = I_imem_data;
        O_instr_pc = pc_q;
      end
    end
  end

  assign pop  = O_valid & I_ready & ~fifo_empty;
  assign push = resp_ok & ~(bypass & I_ready);

  // NOTE: storage carries no reset; it is only ever read behind count != 0.
  always_ff @(posedge I_clk) begin
    if (push) begin
      data_mem[wr_ptr] <= I_imem_data;
      pc_mem[wr_ptr]   <= pc_q;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      inflight <= 1'b0;
      pc_q     <= '0;
    end else begin
      inflight <= O_imem_en;
      if (O_imem_en) pc_q <= I_PC;
      if (I_flush) begin
        count  <= '0;
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        if (push && !pop)      count <= count + 1'b1;
        else if (pop && !push) count <= count - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ceespu_fetch_buffer.sv
// Scoreboard bench for ceespu_fetch_buffer: PC and BRAM models drive the DUT, issued fetches are
// queued and compared in order against what decode receives.
module tb_ceespu_fetch_buffer;

  localparam int ADDR_W = 14;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 4;
`ifdef CEESPU_FETCH_BYPASS_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 2;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              flush;
  logic              ready;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] target;
  logic [DATA_W-1:0] imem_data;
  logic              O_stall, O_imem_en, O_valid;
  logic [ADDR_W-1:0] O_imem_addr, O_instr_pc;
  logic [DATA_W-1:0] O_instr;

  typedef struct {
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] instr;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   delivered = 0;

  ceespu_fetch_buffer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .I_clk      (clk),
    .I_rst      (rst),
    .I_PC       (pc),
    .O_stall    (O_stall),
    .I_flush    (flush),
    .O_imem_en  (O_imem_en),
    .O_imem_addr(O_imem_addr),
    .I_imem_data(imem_data),
    .O_instr    (O_instr),
    .O_instr_pc (O_instr_pc),
    .O_valid    (O_valid),
    .I_ready    (ready)
  );

  always #5 clk = ~clk;

  function automatic logic [DATA_W-1:0] imem_word(logic [ADDR_W-1:0] a);
    return 32'h1000 + DATA_W'(a);
  endfunction

  // Program counter: holds while stalled, loads the branch target on flush.
  always @(posedge clk) begin
    if (rst)           pc <= '0;
    else if (flush)    pc <= target;
    else if (!O_stall) pc <= pc + 1'b1;
  end

  always @(posedge clk) begin
    if (O_imem_en) imem_data <= imem_word(O_imem_addr);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Scoreboard: sampled mid-cycle, when inputs and combinational outputs are settled.
  always @(negedge clk) begin
    if (rst) begin
      check("rst_stall", O_stall, 1);
      check("rst_valid", O_valid, 0);
      sb.delete();
    end else begin
      check("stall", O_stall, 64'(flush || sb.size() >= DEPTH));
      check("imem_en", O_imem_en, 64'(!O_stall));
      check("valid_w_empty", 64'(O_valid && sb.size() == 0), 0);
      if (O_valid && sb.size() != 0) begin
        check("head_pc", O_instr_pc, sb[0].pc);
        check("head_instr", O_instr, sb[0].instr);
        if (ready) begin
          void'(sb.pop_front());
          delivered++;
        end
      end
      if (flush) sb.delete();
      if (O_imem_en) begin
        check("imem_addr", O_imem_addr, pc);
        sb.push_back('{pc, imem_word(pc)});
      end
      check("credit", 64'(sb.size() <= DEPTH), 1);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    int d0;
    logic [ADDR_W-1:0] pc_hold;

    rst = 1'b1; flush = 1'b0; ready = 1'b1; target = '0;
    step(1);
    check("reset_valid", O_valid, 0);
    check("reset_instr", O_instr, 0);
    check("reset_instr_pc", O_instr_pc, 0);
    check("reset_stall", O_stall, 1);
    step(2);

    // Streaming from PC 0 with decode always ready.
    rst = 1'b0;
    #1;
    check("en_after_rst", O_imem_en, 1);
    n = 0;
    do begin step(1); n++; end while (!O_valid && n < 8);
    check("first_latency", n, LAT);
    check("first_pc", O_instr_pc, 0);
    check("first_instr", O_instr, 32'h1000);
    step(1);
    check("second_pc", O_instr_pc, 1);
    step(1);
    check("third_pc", O_instr_pc, 2);
    step(10);
    d0 = delivered;
    step(10);
    check("throughput", delivered - d0, 10);

    // Decode backpressure fills the buffer and freezes the PC.
    ready = 1'b0;
    step(10);
    check("full_stall", O_stall, 1);
    check("full_outstanding", sb.size(), DEPTH);
    check("full_valid", O_valid, 1);
    pc_hold = pc;
    step(2);
    check("pc_frozen", pc, pc_hold);
    ready = 1'b1;
    d0 = delivered;
    step(20);
    check("drain_count", delivered - d0, 20);

    // Flush with two entries queued and one in flight, coincident with a pop.
    ready = 1'b0;
    n = 0;
    while (sb.size() != 3 && n < 10) begin step(1); n++; end
    check("flush_setup", sb.size(), 3);
    ready = 1'b1; flush = 1'b1; target = 14'h0100;
    d0 = delivered;
    #1;
    check("flush_stall", O_stall, 1);
    check("flush_imem_en", O_imem_en, 0);
    step(1);
    flush = 1'b0;
    #1;
    check("flush_pop_counted", delivered - d0, 1);
    check("valid_after_flush", O_valid, 0);
    check("en_after_flush", O_imem_en, 1);
    check("addr_after_flush", O_imem_addr, 14'h0100);
    n = 0;
    do begin step(1); n++; end while (!O_valid && n < 8);
    check("flush_latency", n, LAT);
    check("target_pc", O_instr_pc, 14'h0100);
    check("target_instr", O_instr, 32'h1100);

    // Single-cycle reset with a full buffer.
    ready = 1'b0;
    n = 0;
    while (!O_stall && n < 20) begin step(1); n++; end
    check("prefill_stall", O_stall, 1);
    rst = 1'b1;
    #1;
    check("midrst_valid", O_valid, 0);
    check("midrst_stall", O_stall, 1);
    step(1);
    rst = 1'b0;
    #1;
    check("post_rst_valid", O_valid, 0);
    check("post_rst_en", O_imem_en, 1);
    check("post_rst_addr", O_imem_addr, 0);
    ready = 1'b1;
    n = 0;
    do begin step(1); n++; end while (!O_valid && n < 8);
    check("post_rst_latency", n, LAT);
    check("post_rst_pc", O_instr_pc, 0);

    // Random backpressure and branches; the scoreboard checks ordering throughout.
    for (int i = 0; i < 400; i++) begin
      ready  = ($urandom_range(0, 3) != 0);
      flush  = ($urandom_range(0, 19) == 0);
      target = 14'($urandom);
      step(1);
    end
    flush = 1'b0;
    ready = 1'b1;
    step(12);
    check("final_backlog", 64'(sb.size() <= 2), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
